apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter addr_width, default 32, APB address width.
REQ-002 SHALL have parameter data_width, default 32, APB data width.
REQ-003 SHALL have parameter timeout_cycles, default 16, max ACCESS wait cycles; 0 disables the timeout.
REQ-004 SHALL have one clock and one reset: synchronous, active-high.
REQ-005 pclk  input  1  clock; all logic on its rising edge.
REQ-006 preset  input  1  synchronous active-high reset.
REQ-007 cmd_valid  input  1  command request from local side.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at an edge.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_addr  input  addr_width  transfer address.
REQ-011 cmd_wdata  input  data_width  write data.
REQ-012 rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-013 rsp_rdata  output  data_width  read data; 0 for writes and timeouts.
REQ-014 rsp_error  output  1  pslverr or timeout on the completed transfer.
REQ-015 rsp_timeout  output  1  transfer ended by timeout.
REQ-016 paddr / pwdata / pwrite  output  addr_width / data_width / 1  APB request fields.
REQ-017 psel / penable  output  1 / 1  APB select and enable.
REQ-018 prdata / pready / pslverr  input  data_width / 1 / 1  APB completer response.

Function
REQ-019 SHALL implement FSM IDLE, SETUP, ACCESS; psel = (SETUP|ACCESS), penable = ACCESS, both registered.
REQ-020 cmd_ready SHALL be combinational: high in IDLE, or in ACCESS when pready=1 or the timeout fires this cycle; low otherwise.
REQ-021 On accept, paddr/pwdata/pwrite SHALL register cmd fields and next state SHALL be SETUP.
REQ-022 paddr, pwdata, pwrite SHALL be held stable from SETUP through the final ACCESS cycle.
REQ-023 SETUP SHALL last exactly one cycle, then ACCESS.
REQ-024 ACCESS SHALL persist while pready=0 and no timeout (wait states).
REQ-025 At an ACCESS edge with pready=1: complete; next state SETUP if a new command is accepted at the same edge, else IDLE.
REQ-026 Completion SHALL give rsp_valid=1 the next cycle, with rsp_rdata = prdata (reads) or 0 (writes), rsp_error = pslverr, rsp_timeout=0.
REQ-027 A wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0.
REQ-028 With timeout_cycles>0, the edge at which the counter equals timeout_cycles-1 and pready=0 SHALL terminate the transfer: rsp_valid, rsp_error=1, rsp_timeout=1, rsp_rdata=0.
REQ-029 pready=1 on the timeout cycle SHALL win; normal completion.
REQ-030 Back-to-back: psel SHALL stay 1 and penable SHALL drop to 0 for the new SETUP; no IDLE cycle.
REQ-031 rsp_valid SHALL be low in all non-completion cycles; rsp_* SHALL hold last values otherwise.
REQ-032 Minimum latency, accept edge to rsp_valid: 3 cycles (SETUP, one ACCESS, response).
REQ-033 pready/prdata/pslverr SHALL be ignored outside ACCESS.

Reset
REQ-034 preset=1 at an edge SHALL set state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_timeout=0, wait counter 0.
REQ-035 Reset mid-transfer SHALL abort with no rsp_valid; cmd_ready is low while preset=1.

Verification
REQ-036 Write 0x10 <- 0xDEADBEEF, pready=1 in first ACCESS -> SETUP then ACCESS with psel=1, pwrite=1, fields stable; rsp_valid one cycle later, rsp_error=0.
REQ-037 Read 0x20, 2 wait states, prdata=0x12345678 -> ACCESS held 3 cycles, rsp_rdata=0x12345678, penable low exactly one SETUP cycle.
REQ-038 Read with pslverr=1 at completion -> rsp_error=1, rsp_timeout=0, rdata=prdata.
REQ-039 timeout_cycles=4, pready stuck 0 -> exactly 4 ACCESS cycles, then rsp_error=1, rsp_timeout=1, rsp_rdata=0, psel drops.
REQ-040 Two commands back-to-back -> psel continuously high, second SETUP immediately after first ACCESS, two rsp_valid pulses 2 cycles apart.
REQ-041 preset=1 during ACCESS wait -> next cycle psel=0, penable=0, no rsp_valid; new command after release completes normally.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with a wait-state
// timeout and a one-cycle completion pulse on the local side.
module apb_master #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [data_width-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic [addr_width-1:0] paddr,
    output logic [data_width-1:0] pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic [data_width-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CW = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam bit TO_EN = (timeout_cycles > 0);
    localparam logic [CW-1:0] TO_LAST =
        CW'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic [addr_width-1:0] paddr_q, paddr_d;
    logic [data_width-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [data_width-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic to_fire;
    logic done;
    logic accept;

    always_comb begin
        to_fire   = TO_EN && (state_q == ACCESS) && !pready
                    && (wait_q == TO_LAST);
        done      = (state_q == ACCESS) && (pready || to_fire);
        cmd_ready = !preset && ((state_q == IDLE) || done);
        accept    = cmd_valid && cmd_ready;
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = '0;
            end
            ACCESS: begin
                if (done) begin
                    // pready wins over a timeout landing on the same edge
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = to_fire;
                    rsp_error_d   = to_fire ? 1'b1 : pslverr;
                    rsp_rdata_d   = (to_fire || pwrite_q) ? '0 : prdata;
                    state_d       = accept ? SETUP : IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            pwrite_d = cmd_write;
        end
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pwrite      = pwrite_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_apb_master;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    apb_master #(
        .addr_width(32),
        .data_width(32),
        .timeout_cycles(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, a, e, $time);
        end
    endtask

    // Transaction model: a transfer is busy from accept until it ends;
    // phase 0 is the setup cycle, phase n>=1 is the n-th access cycle.
    bit          en = 0;
    bit          m_busy = 0;
    int          m_phase = 0;
    logic [31:0] m_paddr = '0, m_pwdata = '0;
    logic        m_pwrite = 0;
    logic        m_rv = 0, m_err = 0, m_to = 0;
    logic [31:0] m_rd = '0;
    bit          m_acc, m_dn, m_fr;

    function automatic bit m_fire();
        return (TO > 0) && m_busy && (m_phase == TO) && !pready;
    endfunction

    function automatic bit m_done();
        return m_busy && (m_phase >= 1) && (pready || m_fire());
    endfunction

    function automatic bit m_ready();
        return !preset && (!m_busy || m_done());
    endfunction

    always @(posedge pclk) begin
        if (preset) begin
            en = 1;
            m_busy = 0; m_phase = 0;
            m_paddr = '0; m_pwdata = '0; m_pwrite = 0;
            m_rv = 0; m_rd = '0; m_err = 0; m_to = 0;
        end else begin
            m_acc = cmd_valid && m_ready();
            m_dn = m_done();
            m_fr = m_fire();
            m_rv = 0;
            if (m_dn) begin
                m_rv = 1;
                m_to = m_fr;
                m_err = m_fr ? 1'b1 : pslverr;
                m_rd = (m_fr || m_pwrite) ? 32'h0 : prdata;
                m_busy = 0;
            end else if (m_busy) begin
                m_phase++;
            end
            if (m_acc) begin
                m_busy = 1; m_phase = 0;
                m_paddr = cmd_addr; m_pwdata = cmd_wdata;
                m_pwrite = cmd_write;
            end
        end
    end

    int cyc_n = 0, setup_seen = 0, acc_seen = 0, psel_hi = 0;
    int rsp_cnt = 0, rsp_t = 0, rsp_t_prev = 0;

    always @(negedge pclk) begin
        if (en) begin
            chk("psel", 32'(psel), 32'(m_busy));
            chk("penable", 32'(penable), 32'(m_busy && m_phase >= 1));
            chk("paddr", paddr, m_paddr);
            chk("pwdata", pwdata, m_pwdata);
            chk("pwrite", 32'(pwrite), 32'(m_pwrite));
            chk("cmd_ready", 32'(cmd_ready), 32'(m_ready()));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            chk("rsp_rdata", rsp_rdata, m_rd);
            chk("rsp_error", 32'(rsp_error), 32'(m_err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
        end
        cyc_n++;
        if (psel) psel_hi++;
        if (psel && !penable) setup_seen++;
        if (penable) acc_seen++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_t_prev = rsp_t;
            rsp_t = cyc_n;
        end
    end

    // Completer: wait_n wait states per access; junk outside ACCESS.
    int          wait_n = 0;
    logic [31:0] rd_val = '0;
    logic        err_val = 0;
    int          acc = 0;

    initial begin
        forever begin
            @(posedge pclk);
            #1;
            if (psel && !penable) acc = 0;
            if (penable) begin
                pready = (acc == wait_n);
                prdata = rd_val;
                pslverr = err_val;
                acc++;
            end else begin
                pready = 1'b1;
                prdata = $urandom;
                pslverr = 1'b1;
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        bit ok;
        ok = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge pclk);
            if (cmd_ready) begin
                @(posedge pclk);
                #1;
                ok = 1;
            end
        end
        cmd_valid = 0;
        cmd_addr = $urandom;
        cmd_wdata = $urandom;
        cmd_write = ~w;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout got=none exp=accept");
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(negedge pclk);
            if (rsp_valid) lat = i;
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL rsp_timeout_wait got=none exp=rsp_valid");
        end
    endtask

    task automatic clr();
        setup_seen = 0; acc_seen = 0; psel_hi = 0;
    endtask

    int lat, c0;

    initial begin
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge pclk);
        #1 preset = 0;
        @(negedge pclk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge pclk);
        #1;

        // write, no wait states
        wait_n = 0; rd_val = 32'hFFFF_0000; err_val = 0; clr();
        issue(1, 32'h10, 32'hDEADBEEF);
        wait_rsp(lat);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_rdata", rsp_rdata, 32'd0);
        chk("wr_error", 32'(rsp_error), 32'd0);
        chk("wr_pwdata", pwdata, 32'hDEADBEEF);

        // read, two wait states
        @(posedge pclk); #1;
        wait_n = 2; rd_val = 32'h12345678; err_val = 0; clr();
        issue(0, 32'h20, 32'h0);
        wait_rsp(lat);
        chk("rd_latency", 32'(lat), 32'd5);
        chk("rd_access_cycles", 32'(acc_seen), 32'd3);
        chk("rd_setup_cycles", 32'(setup_seen), 32'd1);
        chk("rd_rdata", rsp_rdata, 32'h12345678);

        // read with slave error
        @(posedge pclk); #1;
        wait_n = 1; rd_val = 32'hA5A50001; err_val = 1; clr();
        issue(0, 32'h24, 32'h0);
        wait_rsp(lat);
        chk("slverr_error", 32'(rsp_error), 32'd1);
        chk("slverr_timeout", 32'(rsp_timeout), 32'd0);
        chk("slverr_rdata", rsp_rdata, 32'hA5A50001);

        // stuck pready: timeout after exactly TO access cycles
        @(posedge pclk); #1;
        wait_n = 255; rd_val = 32'h77777777; err_val = 0; clr();
        issue(0, 32'h28, 32'h0);
        wait_rsp(lat);
        chk("to_latency", 32'(lat), 32'd6);
        chk("to_access_cycles", 32'(acc_seen), 32'd4);
        chk("to_error", 32'(rsp_error), 32'd1);
        chk("to_flag", 32'(rsp_timeout), 32'd1);
        chk("to_rdata", rsp_rdata, 32'd0);
        chk("to_psel_drop", 32'(psel), 32'd0);

        // pready on the would-be timeout cycle completes normally
        @(posedge pclk); #1;
        wait_n = 3; rd_val = 32'h0BADF00D; err_val = 0; clr();
        issue(0, 32'h2C, 32'h0);
        wait_rsp(lat);
        chk("edge_access_cycles", 32'(acc_seen), 32'd4);
        chk("edge_timeout", 32'(rsp_timeout), 32'd0);
        chk("edge_error", 32'(rsp_error), 32'd0);
        chk("edge_rdata", rsp_rdata, 32'h0BADF00D);

        // back-to-back writes
        @(posedge pclk); #1;
        wait_n = 0; err_val = 0; clr();
        c0 = rsp_cnt;
        issue(1, 32'h100, 32'h1);
        issue(1, 32'h104, 32'h2);
        for (int i = 0; i < 20 && rsp_cnt < c0 + 2; i++) @(negedge pclk);
        chk("b2b_rsp_count", 32'(rsp_cnt - c0), 32'd2);
        chk("b2b_rsp_spacing", 32'(rsp_t - rsp_t_prev), 32'd2);
        chk("b2b_psel_cycles", 32'(psel_hi), 32'd4);
        chk("b2b_setup_cycles", 32'(setup_seen), 32'd2);
        chk("b2b_paddr", paddr, 32'h104);

        // reset during an access wait
        @(posedge pclk); #1;
        wait_n = 255; clr();
        c0 = rsp_cnt;
        issue(0, 32'h30, 32'h0);
        @(posedge pclk); #1;
        preset = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h99;
        @(negedge pclk);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge pclk); #1;
        preset = 0; cmd_valid = 0;
        @(negedge pclk);
        chk("rst_mid_psel", 32'(psel), 32'd0);
        chk("rst_mid_penable", 32'(penable), 32'd0);
        chk("rst_mid_paddr", paddr, 32'd0);
        @(posedge pclk); #1;
        chk("rst_mid_no_rsp", 32'(rsp_cnt - c0), 32'd0);
        wait_n = 0; rd_val = 32'h55AA33CC; err_val = 0;
        issue(0, 32'h40, 32'h0);
        wait_rsp(lat);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_rdata", rsp_rdata, 32'h55AA33CC);
        chk("post_rst_error", 32'(rsp_error), 32'd0);

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit got=hang exp=finish");
        $fatal(1, "time limit");
    end

endmodule
